instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly downstream of the flash-loaded SPRAM instruction ROM.
- Holds the CPU off until the ROM reports ready, then drives the ROM address and absorbs its one-cycle read latency.
- Presents each instruction with its PC and a valid flag to the Hack CPU; handles jumps and stalls with no bubbles.
- Flags a sticky fault when fetch runs past the loaded program image.

Parameters:
- RESET_VECTOR, 16'h0000, first address fetched after boot.
- ROM_WORDS, 32768, number of loaded words; any address >= ROM_WORDS is out of range.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  synchronous active-low reset.
- clken  input  1  global clock enable; state advances only when high.
- rom_ready  input  1  ROM load complete.
- rom_address  output  16  address to ROM; combinational.
- rom_instruction  input  16  ROM data for the address presented on the previous edge.
- stall  input  1  CPU not consuming the current instruction.
- jump  input  1  CPU consumes the current instruction; the next instruction comes from jump_target.
- jump_target  input  16  branch destination; sampled only with jump.
- instr  output  16  current instruction; equals rom_instruction.
- instr_pc  output  16  address of instr.
- instr_valid  output  1  instr/instr_pc are meaningful.
- fault  output  1  sticky out-of-range fetch flag.
- retired  output  32  count of consumed instructions.

Behaviour:
- Registers: state {BOOT, RUN, FAULT}, fetch_pc[15:0], inflight_pc[15:0], inflight_valid, retired[31:0].
- Reset (resetn=0 at an edge): state=BOOT, fetch_pc=RESET_VECTOR, inflight_pc=RESET_VECTOR, inflight_valid=0, retired=0. Reset overrides all other inputs and applies mid-run.
- Outputs are derived from registers: instr_valid = inflight_valid && state==RUN; instr_pc = inflight_pc; fault = (state==FAULT); instr = rom_instruction, passed through.
- advance = clken && ((state==RUN && !stall) || (state==BOOT && rom_ready)).
- next_addr:
  - BOOT: RESET_VECTOR.
  - RUN: jump ? jump_target : fetch_pc.
- rom_address = advance ? next_addr : inflight_pc.
  - Re-reading inflight_pc while stalled or clken=0 keeps rom_instruction stable for the held instr.
- On an advance edge with next_addr < ROM_WORDS:
  - inflight_pc <= next_addr; fetch_pc <= next_addr+1, 16-bit wrap; inflight_valid <= 1; state <= RUN.
- On an advance edge with next_addr >= ROM_WORDS:
  - state <= FAULT; inflight_valid <= 0; fetch_pc and inflight_pc unchanged.
- retired increments by 1, wrapping at 2^32, on any edge where clken && state==RUN && instr_valid && !stall. A jump counts as a consume.
- Jump latency: the instruction at jump_target is instr_valid in the cycle immediately after the jump edge (zero bubbles).
- Sequential latency: one instruction per clken cycle while stall=0.
- jump while stall=1 is ignored; the stall has priority.
- BOOT: instr_valid=0 and rom_address=RESET_VECTOR; waits indefinitely for rom_ready. The first advance happens on the first edge with rom_ready && clken.
- RUN: rom_ready deasserting is ignored.
- FAULT: terminal until reset. instr_valid=0, rom_address=inflight_pc, retired frozen, stall/jump ignored.
- clken=0: no register changes, including retired; outputs hold.
- Boundary:
  - The instruction at address ROM_WORDS-1 issues normally; the following sequential fetch faults.
  - A jump_target >= ROM_WORDS faults in the same edge and never issues.
  - With ROM_WORDS=65536, fetch_pc 16'hFFFF+1 wraps to 0 and no fault occurs.

Test Plan:
- Boot hold: rom_ready=0 for 100 cycles, clken=1 -> instr_valid=0, rom_address=0, retired=0. Raise rom_ready -> one cycle later instr_pc=0, instr_valid=1, rom_address=1.
- Sequential run: ROM[n]=n+16'hA000, stall=0, jump=0 for 5 cycles -> instr_pc 0,1,2,3,4 with instr A000..A004 on consecutive cycles; retired=5.
- Stall hold: stall=1 for 3 cycles at instr_pc=2 -> instr=A002, instr_pc=2, rom_address=2, retired unchanged. Release -> next cycle instr_pc=3.
- Jump, no bubble: at instr_pc=3, jump=1, jump_target=16'h0100 -> next cycle instr_pc=0x100, instr=ROM[0x100], valid=1, retired+1. Repeat with stall=1 and jump=1 -> jump ignored.
- End of image: jump to 16'h7FFE, run 2 cycles (ROM_WORDS=32768) -> 0x7FFE and 0x7FFF issue, then fault=1, instr_valid=0. Jump to 16'h8000 from RUN -> fault=1 on the next cycle, target never valid.
- clken gating and reset: toggle clken 1/0 during a run -> PC advances only on clken=1 cycles. resetn=0 for one edge mid-run -> state BOOT, instr_valid=0, retired=0, fault cleared, rom_address=RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage between the SPRAM instruction ROM and the Hack CPU.
// Absorbs the one-cycle ROM latency so sequential fetches and jumps issue with no bubbles.
module instr_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned ROM_WORDS    = 32768
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clken,
    input  logic        rom_ready,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_instruction,
    input  logic        stall,
    input  logic        jump,
    input  logic [15:0] jump_target,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    // Seventeen bits so that a full 64K-word image never reports out of range.
    localparam logic [16:0] ROM_LIMIT = 17'(ROM_WORDS);

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_valid_q, inflight_valid_d;
    logic [31:0] retired_q, retired_d;

    logic        advance_s;
    logic        in_range_s;
    logic        consume_s;
    logic [15:0] next_addr_s;

    // Fetch address selection and ROM address steering.
    always_comb begin
        advance_s   = 1'b0;
        next_addr_s = RESET_VECTOR;
        case (state_q)
            BOOT: begin
                next_addr_s = RESET_VECTOR;
                advance_s   = clken && rom_ready;
            end
            RUN: begin
                next_addr_s = jump ? jump_target : fetch_pc_q;
                advance_s   = clken && !stall;
            end
            FAULT: begin
                next_addr_s = inflight_pc_q;
                advance_s   = 1'b0;
            end
            default: begin
                next_addr_s = RESET_VECTOR;
                advance_s   = 1'b0;
            end
        endcase
        in_range_s  = ({1'b0, next_addr_s} < ROM_LIMIT);
        consume_s   = clken && (state_q == RUN) && inflight_valid_q && !stall;
        rom_address = advance_s ? next_addr_s : inflight_pc_q;
    end

    // Next-state computation for the fetch pointers, state and retire counter.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        if (advance_s) begin
            if (in_range_s) begin
                inflight_pc_d    = next_addr_s;
                fetch_pc_d       = next_addr_s + 16'd1;
                inflight_valid_d = 1'b1;
                state_d          = RUN;
            end else begin
                inflight_valid_d = 1'b0;
                state_d          = FAULT;
            end
        end else begin
            state_d = state_q;
        end
        if (consume_s) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q          <= BOOT;
            fetch_pc_q       <= RESET_VECTOR;
            inflight_pc_q    <= RESET_VECTOR;
            inflight_valid_q <= 1'b0;
            retired_q        <= 32'd0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            retired_q        <= retired_d;
        end
    end

    assign instr       = rom_instruction;
    assign instr_pc    = inflight_pc_q;
    assign instr_valid = inflight_valid_q && (state_q == RUN);
    assign fault       = (state_q == FAULT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the boot/stall/jump/boundary
// scenarios, then random stimulus against a behavioural fetch model.
module tb_instr_fetch;

    localparam logic [15:0] RV    = 16'h0000;
    localparam logic [16:0] LIMIT = 17'd32768;

    logic        clk;
    logic        resetn;
    logic        clken;
    logic        rom_ready;
    logic [15:0] rom_address;
    logic [15:0] rom_instruction;
    logic        stall;
    logic        jump;
    logic [15:0] jump_target;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        fault;
    logic [31:0] retired;

    int n_cmp;
    int n_err;

    instr_fetch #(.RESET_VECTOR(16'h0000), .ROM_WORDS(32768)) dut (
        .clk(clk), .resetn(resetn), .clken(clken), .rom_ready(rom_ready),
        .rom_address(rom_address), .rom_instruction(rom_instruction),
        .stall(stall), .jump(jump), .jump_target(jump_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return a + 16'hA000;
    endfunction

    // ROM with one-cycle read latency.
    always @(posedge clk) rom_instruction <= rom_word(rom_address);

    // Behavioural model: what the CPU should see.
    bit          m_run;
    bit          m_fault;
    logic [15:0] m_pc;
    logic [31:0] m_ret;

    task automatic issue(input logic [15:0] a);
        if ({1'b0, a} < LIMIT) begin
            m_pc  = a;
            m_run = 1'b1;
        end else begin
            m_fault = 1'b1;
            m_run   = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_run = 1'b0; m_fault = 1'b0; m_pc = RV; m_ret = 32'd0;
        end else if (clken && !m_fault) begin
            if (!m_run) begin
                if (rom_ready) issue(RV);
            end else if (!stall) begin
                m_ret = m_ret + 32'd1;
                issue(jump ? jump_target : m_pc + 16'd1);
            end
        end
    endtask

    function automatic logic [15:0] model_addr();
        if (m_fault) return m_pc;
        if (!m_run) return (clken && rom_ready) ? RV : m_pc;
        if (clken && !stall) return jump ? jump_target : m_pc + 16'd1;
        return m_pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst_n, ce, rdy, stl, jmp;
        logic [15:0] jt;
        int          reps;
        logic        e_valid;
        logic [15:0] e_pc, e_addr;
        logic        e_fault;
        logic [31:0] e_ret;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic c, input logic y, input logic s,
                                 input logic j, input logic [15:0] t, input int n,
                                 input logic v, input logic [15:0] p, input logic [15:0] a,
                                 input logic f, input logic [31:0] rt);
        vec_t x;
        x.rst_n = r; x.ce = c; x.rdy = y; x.stl = s; x.jmp = j; x.jt = t; x.reps = n;
        x.e_valid = v; x.e_pc = p; x.e_addr = a; x.e_fault = f; x.e_ret = rt;
        return x;
    endfunction

    // Expected values are the outputs seen with the entry's inputs applied, before its edge.
    vec_t tbl[26];

    initial begin
        n_cmp = 0;
        n_err = 0;
        tbl[0]  = mkv(1, 1, 0, 0, 0, 16'h0000, 100, 0, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[1]  = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[2]  = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001, 0, 32'd0);
        tbl[3]  = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002, 0, 32'd1);
        tbl[4]  = mkv(1, 1, 1, 1, 0, 16'h0000, 3, 1, 16'h0002, 16'h0002, 0, 32'd2);
        tbl[5]  = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h0003, 0, 32'd2);
        tbl[6]  = mkv(1, 1, 1, 0, 1, 16'h0100, 1, 1, 16'h0003, 16'h0100, 0, 32'd3);
        tbl[7]  = mkv(1, 1, 1, 1, 1, 16'h0200, 1, 1, 16'h0100, 16'h0100, 0, 32'd4);
        tbl[8]  = mkv(1, 1, 1, 0, 1, 16'h7FFE, 1, 1, 16'h0100, 16'h7FFE, 0, 32'd4);
        tbl[9]  = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h7FFE, 16'h7FFF, 0, 32'd5);
        tbl[10] = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h7FFF, 16'h8000, 0, 32'd6);
        tbl[11] = mkv(1, 1, 1, 0, 0, 16'h0000, 2, 0, 16'h7FFF, 16'h7FFF, 1, 32'd7);
        tbl[12] = mkv(1, 1, 1, 0, 1, 16'h0000, 1, 0, 16'h7FFF, 16'h7FFF, 1, 32'd7);
        tbl[13] = mkv(0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h7FFF, 16'h7FFF, 1, 32'd7);
        tbl[14] = mkv(1, 0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[15] = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[16] = mkv(1, 1, 1, 0, 1, 16'h8000, 1, 1, 16'h0000, 16'h8000, 0, 32'd0);
        tbl[17] = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 32'd1);
        tbl[18] = mkv(0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 32'd1);
        tbl[19] = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[20] = mkv(1, 0, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 32'd0);
        tbl[21] = mkv(1, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001, 0, 32'd0);
        tbl[22] = mkv(1, 0, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 0, 32'd1);
        tbl[23] = mkv(1, 1, 0, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002, 0, 32'd1);
        tbl[24] = mkv(0, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h0003, 0, 32'd2);
        tbl[25] = mkv(1, 1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 32'd0);

        resetn = 1'b0; clken = 1'b1; rom_ready = 1'b0;
        stall = 1'b0; jump = 1'b0; jump_target = 16'h0000;
        @(negedge clk);
        tick();

        for (int i = 0; i < 26; i++) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                resetn = tbl[i].rst_n; clken = tbl[i].ce; rom_ready = tbl[i].rdy;
                stall = tbl[i].stl; jump = tbl[i].jmp; jump_target = tbl[i].jt;
                #1;
                check($sformatf("vec%0d.valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
                check($sformatf("vec%0d.pc", i), 32'(instr_pc), 32'(tbl[i].e_pc));
                check($sformatf("vec%0d.addr", i), 32'(rom_address), 32'(tbl[i].e_addr));
                check($sformatf("vec%0d.fault", i), 32'(fault), 32'(tbl[i].e_fault));
                check($sformatf("vec%0d.retired", i), retired, tbl[i].e_ret);
                if (tbl[i].e_valid)
                    check($sformatf("vec%0d.instr", i), 32'(instr), 32'(rom_word(tbl[i].e_pc)));
                tick();
            end
        end

        for (int c = 0; c < 3000; c++) begin
            int r;
            resetn    = ($urandom_range(0, 63) != 0);
            clken     = ($urandom_range(0, 4) != 0);
            rom_ready = ($urandom_range(0, 1) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            jump      = ($urandom_range(0, 6) == 0);
            r = int'($urandom_range(0, 9));
            if (r == 0)
                jump_target = 16'h8000 | 16'($urandom_range(0, 32767));
            else if (r < 3)
                jump_target = 16'h7FF0 | 16'($urandom_range(0, 15));
            else
                jump_target = 16'($urandom_range(0, 32767));
            #1;
            check("rnd.valid", 32'(instr_valid), 32'(m_run));
            check("rnd.pc", 32'(instr_pc), 32'(m_pc));
            check("rnd.addr", 32'(rom_address), 32'(model_addr()));
            check("rnd.fault", 32'(fault), 32'(m_fault));
            check("rnd.retired", retired, m_ret);
            if (m_run) check("rnd.instr", 32'(instr), 32'(rom_word(m_pc)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
